// File: rtl/snake_dir_ctrl_if.sv
// Handshake bundle between the edge-detect stage, snake_dir_ctrl and the body/position logic.
// Optional drop_cnt exists only when SNAKE_DIR_STATS_EN is defined.
interface snake_dir_ctrl_if;
    logic [3:0] direction_i;
    logic       move_tick_i;
    logic       game_en_i;
    logic       badColl_i;
    logic [3:0] heading;
    logic       turn_o;
    logic       reject_o;
    logic [2:0] queue_cnt;
    logic       dead_o;
`ifdef SNAKE_DIR_STATS_EN
    logic [7:0] drop_cnt;
`endif

    modport master (
        output direction_i, move_tick_i, game_en_i, badColl_i,
`ifdef SNAKE_DIR_STATS_EN
        input  drop_cnt,
`endif
        input  heading, turn_o, reject_o, queue_cnt, dead_o
    );

    modport slave (
        input  direction_i, move_tick_i, game_en_i, badColl_i,
`ifdef SNAKE_DIR_STATS_EN
        output drop_cnt,
`endif
        output heading, turn_o, reject_o, queue_cnt, dead_o
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake heading control: queues legal turn requests and commits one per move tick; 1-cycle registered latency.
// No backpressure: requests arriving on a full queue are dropped with reject_o. SNAKE_DIR_STATS_EN adds drop_cnt.
module snake_dir_ctrl #(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [3:0] INIT_DIR    = 4'b0001
) (
    input  logic             clk,
    input  logic             rst,
    snake_dir_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [1:0] PTR_LAST = 2'(QUEUE_DEPTH - 1);
    localparam logic [2:0] CNT_MAX  = 3'(QUEUE_DEPTH);

    state_t     state_q, state_d;
    logic       run_act, dead_flag;
    logic [3:0] fifo_q [4];
    logic [1:0] wr_ptr, rd_ptr, last_ptr;
    logic [2:0] cnt_q;
    logic [3:0] heading_q, ref_dir, opp_dir;
    logic       turn_q, reject_q;
    logic       req, one_hot, legal, push, pop, rej;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.game_en_i) state_d = RUN;
            RUN:     if (!bus.game_en_i) state_d = IDLE;
                     else if (bus.badColl_i) state_d = DEAD;
            DEAD:    if (!bus.game_en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A collision in the same cycle as a tick already blocks the pop here.
    always_comb begin
        run_act   = (state_q == RUN) && bus.game_en_i && !bus.badColl_i;
        dead_flag = (state_q == DEAD);
    end

    // Requests are judged against the newest queued turn, so a chain of turns stays consistent.
    always_comb begin
        last_ptr = (wr_ptr == 2'd0) ? PTR_LAST : wr_ptr - 2'd1;
        ref_dir  = (cnt_q != 3'd0) ? fifo_q[last_ptr] : heading_q;
        opp_dir  = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
        req      = |bus.direction_i;
        one_hot  = (bus.direction_i & (bus.direction_i - 4'd1)) == 4'd0;
        legal    = req && one_hot && (bus.direction_i != ref_dir) && (bus.direction_i != opp_dir);
        pop      = run_act && bus.move_tick_i && (cnt_q != 3'd0);
        push     = run_act && legal && ((cnt_q < CNT_MAX) || pop);
        rej      = run_act && req && !push;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= bus.direction_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heading_q <= INIT_DIR;
            turn_q    <= 1'b0;
            reject_q  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            cnt_q     <= 3'd0;
        end else begin
            turn_q   <= pop;
            reject_q <= rej;
            if (!run_act) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                cnt_q  <= 3'd0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop) begin
                    heading_q <= fifo_q[rd_ptr];
                    rd_ptr    <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + 3'd1;
                    2'b01:   cnt_q <= cnt_q - 3'd1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

`ifdef SNAKE_DIR_STATS_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else if ((state_q == IDLE) || !bus.game_en_i) begin
            drop_q <= 8'd0;
        end else if (reject_q && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif

    assign bus.heading   = heading_q;
    assign bus.turn_o    = turn_q;
    assign bus.reject_o  = reject_q;
    assign bus.queue_cnt = cnt_q;
    assign bus.dead_o    = dead_flag;
endmodule
